// File: rtl/pipeline_elastic_stage.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready handshake
// and the stage-controller semantics (nullify, stall, bubble, keep_exception).
module pipeline_elastic_stage #(
  parameter int WIDTH     = 64,
  parameter int EXC_WIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [EXC_WIDTH-1:0]         in_exc,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [EXC_WIDTH-1:0]         out_exc,
  output logic                         out_killed,
  input  logic                         out_ready,
  input  logic                         nullify,
  input  logic                         stall,
  input  logic                         bubble,
  input  logic                         keep_exception,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]     mem_data   [DEPTH];
  logic [EXC_WIDTH-1:0] mem_exc    [DEPTH];
  logic                 mem_killed [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;
  logic          empty, full, enq, deq, keep_head;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign in_ready  = ~full & ~stall & ~nullify;
  assign out_valid = ~empty & ~stall & ~bubble & ~nullify;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign count     = count_q;

  // Head is masked to zero when empty, so storage never needs a reset.
  assign out_data   = empty ? '0 : mem_data[rd_ptr];
  assign out_exc    = empty ? '0 : mem_exc[rd_ptr];
  assign out_killed = empty ? 1'b0 : mem_killed[rd_ptr];

  assign keep_head = nullify & keep_exception & ~empty & (out_exc != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (nullify) begin
      rd_ptr <= '0;
      if (keep_head) begin
        wr_ptr  <= ptr_inc('0);
        count_q <= CW'(1);
      end else begin
        wr_ptr  <= '0;
        count_q <= '0;
      end
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The surviving exception remnant is relocated to slot 0 on a keeping nullify.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (keep_head) begin
        mem_data[0]   <= '0;
        mem_exc[0]    <= out_exc;
        mem_killed[0] <= 1'b1;
      end else if (enq) begin
        mem_data[wr_ptr]   <= in_data;
        mem_exc[wr_ptr]    <= in_exc;
        mem_killed[wr_ptr] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// Bench for pipeline_elastic_stage: DEPTH=2 and DEPTH=3 instances share stimulus
// and are each checked every cycle against a queue model, plus literal checks.
module tb_pipeline_elastic_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_exc = '0;
  logic        out_ready = 1'b0;
  logic        nullify = 1'b0;
  logic        stall = 1'b0;
  logic        bubble = 1'b0;
  logic        keep_exception = 1'b0;

  logic        in_ready2, out_valid2, out_killed2;
  logic [63:0] out_data2;
  logic [7:0]  out_exc2;
  logic [1:0]  count2;
  logic        in_ready3, out_valid3, out_killed3;
  logic [63:0] out_data3;
  logic [7:0]  out_exc3;
  logic [1:0]  count3;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipeline_elastic_stage #(.WIDTH(64), .EXC_WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_exc(in_exc),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_exc(out_exc2),
    .out_killed(out_killed2), .out_ready(out_ready), .nullify(nullify), .stall(stall),
    .bubble(bubble), .keep_exception(keep_exception), .count(count2));

  pipeline_elastic_stage #(.WIDTH(64), .EXC_WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_exc(in_exc),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_exc(out_exc3),
    .out_killed(out_killed3), .out_ready(out_ready), .nullify(nullify), .stall(stall),
    .bubble(bubble), .keep_exception(keep_exception), .count(count3));

  typedef struct {
    logic [63:0] data;
    logic [7:0]  exc;
    logic        killed;
  } ent_t;
  typedef ent_t ent_q_t[$];

  ent_q_t q2, q3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of the buffer's contract, applied to an ordered list of entries.
  function automatic ent_q_t model_step(input ent_q_t q, input int d);
    ent_q_t r = q;
    int     n = q.size();
    ent_t   e;
    logic   take, give;
    if (nullify) begin
      if (keep_exception && n != 0 && q[0].exc != 0) begin
        e.data = '0; e.exc = q[0].exc; e.killed = 1'b1;
        r.delete();
        r.push_back(e);
      end else begin
        r.delete();
      end
    end else begin
      take = in_valid && (n < d) && !stall;
      give = out_ready && (n != 0) && !stall && !bubble;
      if (give) void'(r.pop_front());
      if (take) begin
        e.data = in_data; e.exc = in_exc; e.killed = 1'b0;
        r.push_back(e);
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q2.delete();
      q3.delete();
    end else begin
      q2 = model_step(q2, 2);
      q3 = model_step(q3, 3);
    end
  end

  task automatic check_dut(input string tag, input ent_q_t q, input int d,
                           input logic ir, input logic ov, input logic [63:0] od,
                           input logic [7:0] oe, input logic ok, input logic [1:0] cnt);
    int   n = q.size();
    ent_t h;
    h.data = '0; h.exc = '0; h.killed = 1'b0;
    if (n != 0) h = q[0];
    chk({tag, " in_ready"},   64'(ir),  64'((n < d) && !stall && !nullify));
    chk({tag, " out_valid"},  64'(ov),  64'((n != 0) && !stall && !bubble && !nullify));
    chk({tag, " out_data"},   od,       h.data);
    chk({tag, " out_exc"},    64'(oe),  64'(h.exc));
    chk({tag, " out_killed"}, 64'(ok),  64'(h.killed));
    chk({tag, " count"},      64'(cnt), 64'(n));
  endtask

  always @(negedge clk) begin
    check_dut("d2", q2, 2, in_ready2, out_valid2, out_data2, out_exc2, out_killed2, count2);
    check_dut("d3", q3, 3, in_ready3, out_valid3, out_data3, out_exc3, out_killed3, count3);
  end

  logic [63:0] got[$];
  logic        rec_en = 1'b0;
  int          max_cnt3 = 0;

  always @(negedge clk) begin
    if (rec_en && !reset) begin
      if (int'(count3) > max_cnt3) max_cnt3 = int'(count3);
      if (out_valid3 && out_ready) got.push_back(out_data3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst out_valid", 64'(out_valid2), 64'd0);
    chk("rst count",     64'(count2),     64'd0);
    chk("rst in_ready",  64'(in_ready2),  64'd1);
    chk("rst out_data",  out_data2,       64'd0);
    reset = 1'b0;

    // fill / drain
    in_valid = 1'b1; in_data = 64'hA; tick();
    in_data = 64'hB; tick();
    in_valid = 1'b0; #1;
    chk("fill count",    64'(count2),    64'd2);
    chk("fill in_ready", 64'(in_ready2), 64'd0);
    chk("fill head",     out_data2,      64'hA);
    out_ready = 1'b1; tick();
    chk("drain head B", out_data2,      64'hB);
    chk("drain count1", 64'(count2),    64'd1);
    tick();
    chk("drain count0", 64'(count2),    64'd0);
    chk("drain data0",  out_data2,      64'd0);

    // streaming wrap-around
    rec_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = 64'(i); tick();
    end
    in_valid = 1'b0; tick();
    rec_en = 1'b0; out_ready = 1'b0;
    chk("wrap delivered", 64'(got.size()), 64'd10);
    if (got.size() == 10)
      for (int i = 0; i < 10; i++) chk("wrap order", got[i], 64'(i + 1));
    chk("wrap max count", 64'(max_cnt3), 64'd1);

    // stall vs bubble
    in_valid = 1'b1; in_data = 64'h11; tick();
    in_data = 64'h22; stall = 1'b1; #1;
    chk("stall in_ready",  64'(in_ready2),  64'd0);
    chk("stall out_valid", 64'(out_valid2), 64'd0);
    tick();
    chk("stall count", 64'(count2), 64'd1);
    chk("stall head",  out_data2,   64'h11);
    stall = 1'b0; bubble = 1'b1; out_ready = 1'b1; in_data = 64'h33; #1;
    chk("bubble out_valid", 64'(out_valid2), 64'd0);
    chk("bubble in_ready",  64'(in_ready2),  64'd1);
    tick();
    chk("bubble count", 64'(count2), 64'd2);
    chk("bubble head",  out_data2,   64'h11);
    bubble = 1'b0;

    // full: dequeue but no write-through
    in_data = 64'h44; #1;
    chk("full in_ready", 64'(in_ready2), 64'd0);
    tick();
    chk("no wt count", 64'(count2), 64'd1);
    chk("no wt head",  out_data2,   64'h33);
    out_ready = 1'b0; in_data = 64'h45; tick();

    // nullify without keep
    nullify = 1'b1; in_data = 64'h46; #1;
    chk("null in_ready",  64'(in_ready2),  64'd0);
    chk("null out_valid", 64'(out_valid2), 64'd0);
    tick();
    nullify = 1'b0; in_valid = 1'b0; #1;
    chk("null count",     64'(count2),     64'd0);
    chk("null out_valid", 64'(out_valid2), 64'd0);
    chk("null out_data",  out_data2,       64'd0);

    // nullify keeping the head exception
    in_valid = 1'b1; in_data = 64'h55; in_exc = 8'h0C; tick();
    in_data = 64'h66; in_exc = 8'h00; tick();
    in_valid = 1'b0;
    nullify = 1'b1; keep_exception = 1'b1; tick();
    nullify = 1'b0; keep_exception = 1'b0; #1;
    chk("keep count",     64'(count2),      64'd1);
    chk("keep out_exc",   64'(out_exc2),    64'h0C);
    chk("keep out_data",  out_data2,        64'd0);
    chk("keep killed",    64'(out_killed2), 64'd1);
    chk("keep out_valid", 64'(out_valid2),  64'd1);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; #1;
    chk("keep drain count",  64'(count2),      64'd0);
    chk("keep drain killed", 64'(out_killed2), 64'd0);

    // asynchronous reset between edges
    in_valid = 1'b1; in_data = 64'h77; tick();
    in_data = 64'h88; tick();
    in_valid = 1'b0; #1;
    chk("pre-rst count", 64'(count2), 64'd2);
    reset = 1'b1; #1;
    chk("arst out_valid", 64'(out_valid2), 64'd0);
    chk("arst count",     64'(count2),     64'd0);
    chk("arst out_data",  out_data2,       64'd0);
    chk("arst count d3",  64'(count3),     64'd0);
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 64'h99; #1;
    chk("post-rst pre-edge", 64'(count2), 64'd0);
    tick();
    in_valid = 1'b0; #1;
    chk("post-rst count", 64'(count2), 64'd1);
    chk("post-rst head",  out_data2,   64'h99);

    // keep_exception with a clean head flushes everything
    nullify = 1'b1; keep_exception = 1'b1; tick();
    nullify = 1'b0; keep_exception = 1'b0; #1;
    chk("keep clean count", 64'(count2), 64'd0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic_stage.md
# pipeline_elastic_stage

Parametrised successor to the single-entry pipeline stage register. It buffers up to DEPTH payload entries between two pipeline stages using a valid/ready handshake. It keeps the existing controller semantics: nullify, stall, bubble and keep_exception. It sits between any two of fetch/decode/execute/memory/writeback, so a multi-cycle consumer (multiplier, divider, memory wait) can absorb upstream issue without stalling the whole front end.

## Interface
Parameters:
- WIDTH, 64, payload bits per entry (flattened stage signal bundle).
- EXC_WIDTH, 8, exception-code bits per entry; zero means no exception.
- DEPTH, 2, number of buffer entries; legal range 1..16, not required to be a power of two.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents an entry.
- in_data  in  WIDTH  upstream payload.
- in_exc  in  EXC_WIDTH  upstream exception code.
- in_ready  out  1  stage accepts an entry this cycle.
- out_valid  out  1  head entry offered downstream.
- out_data  out  WIDTH  head payload; zero when empty.
- out_exc  out  EXC_WIDTH  head exception code; zero when empty.
- out_killed  out  1  head entry is an exception-only remnant of a nullify.
- out_ready  in  1  downstream consumes the head.
- nullify  in  1  flush all entries.
- stall  in  1  freeze: no enqueue, no dequeue.
- bubble  in  1  block dequeue only; enqueue still allowed.
- keep_exception  in  1  with nullify, preserve the head exception.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {data, exc, killed}.
- Read and write pointers wrap explicitly from DEPTH-1 to 0, not modulo 2^n.
- Control priority: reset > nullify > stall > bubble > handshake.
- in_ready = (count < DEPTH) & ~stall & ~nullify. No write-through when full, even if a dequeue happens in the same cycle.
- out_valid = (count != 0) & ~stall & ~bubble & ~nullify.
- Enqueue (in_valid & in_ready): write in_data/in_exc with killed=0 at the write pointer, then advance the pointer.
- Dequeue (out_valid & out_ready): advance the read pointer.
- Enqueue and dequeue in the same cycle: count is unchanged.
- out_data, out_exc and out_killed always show the head entry combinationally from storage, regardless of out_valid. All three read zero when count==0.
- Nullify, with keep_exception=0 or head exc==0 or count==0:
  - next cycle count=0 and both pointers reset to 0.
  - in_data is discarded that cycle.
- Nullify, with keep_exception=1, count!=0 and head exc!=0:
  - next cycle count=1, with the entry at index 0 = {data=0, exc=old head exc, killed=1}.
  - read pointer=0, write pointer=1 (wrapping to 0 when DEPTH=1).
- A killed entry dequeues like any other entry.
- Stall: pointers, count and storage hold. The outputs are still driven from the head.
- Bubble: same as a normal cycle except that no dequeue occurs.
- Reset:
  - pointers=0 and count=0.
  - out_valid=0, out_data=0, out_exc=0, out_killed=0.
  - in_ready=1 unless stall or nullify is asserted.
  - Storage contents need no reset, because outputs are masked to zero when empty.

## Timing
- Latency: an entry accepted at edge N is visible at out_* and can be dequeued in cycle N+1. There is no combinational in→out bypass.
- in_ready and out_valid depend combinationally on stall/bubble/nullify, and never on in_valid or out_ready. There are no handshake loops.
- Throughput: 1 entry/cycle while 0 < count < DEPTH. When full, at most 1 entry per 2 cycles for DEPTH=1, because no write-through is allowed.
- nullify takes effect at the next edge. During the nullify cycle itself, neither handshake fires.
- Asserting reset mid-operation clears the state immediately and asynchronously. Outputs reach their reset values without waiting for a clock edge.
- count is registered. It updates one edge after the handshake.

## Test plan
- Fill/drain, DEPTH=2:
  - enqueue 0xA, 0xB with out_ready=0 → count=2, in_ready=0, out_data=0xA.
  - raise out_ready → 0xA, then 0xB on consecutive cycles; count returns to 0 and out_data=0.
- Wrap-around, DEPTH=3:
  - stream 10 entries 1..10 with out_ready=1.
  - → every value is delivered in order exactly once, the pointers wrap at 2→0, and count never exceeds 1.
- Stall vs bubble with count=1:
  - stall=1, in_valid=1 → no change.
  - bubble=1, in_valid=1, out_ready=1 → out_valid=0, count becomes 2, head unchanged.
- Nullify, keep_exception=0, count=2 → next cycle count=0, out_valid=0, and in_data offered during the nullify cycle is lost.
- Nullify, keep_exception=1, head exc=0x0C, count=2 → next cycle count=1, out_exc=0x0C, out_data=0, out_killed=1. One dequeue then leaves count=0.
- Asynchronous reset asserted between edges while count=2 → out_valid=0 and count=0 before the next rising edge. After release, the first enqueue is seen at the next edge.
